// File: rtl/approx_sub_pipe_pkg.sv
// Shared widths and payload types for the pipelined approximate subtractor.
package approx_sub_pipe_pkg;

    localparam int unsigned DATA_W   = 24;
    localparam int unsigned PREC_W   = 8;
    localparam int unsigned APPROX_W = 16;

    // Operand payload captured by stage 1
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              borrow_in;
        logic              exact_mode;
    } stage_t;

endpackage

// File: rtl/approx_sub_core.sv
// Combinational core: produces both the approximate and the exact 24-bit difference.
module approx_sub_core
    import approx_sub_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              borrow_in,
    output logic [DATA_W-1:0] approx_diff,
    output logic              approx_borrow,
    output logic [DATA_W-1:0] exact_diff,
    output logic              exact_borrow
);

    localparam int unsigned HI_W  = PREC_W + 1;
    localparam int unsigned SUM_W = DATA_W + 1;

    logic [DATA_W-1:0] b_inv;
    logic              carry_in;
    logic              c_lo;
    logic [HI_W-1:0]   hi_sum;
    logic [SUM_W-1:0]  full_sum;

    // Subtraction as a + ~b + ~borrow_in; the low part uses the OR approximation
    always_comb begin
        b_inv    = ~b;
        carry_in = ~borrow_in;
        c_lo     = a[APPROX_W-1] & b_inv[APPROX_W-1];
        hi_sum   = HI_W'(a[DATA_W-1:APPROX_W]) + HI_W'(b_inv[DATA_W-1:APPROX_W])
                 + HI_W'(carry_in);
        full_sum = SUM_W'(a) + SUM_W'(b_inv) + SUM_W'(carry_in);

        approx_diff   = {hi_sum[PREC_W-1:0], a[APPROX_W-1:0] | b_inv[APPROX_W-1:0]};
        approx_borrow = ~(hi_sum[PREC_W] | c_lo);
        exact_diff    = full_sum[DATA_W-1:0];
        exact_borrow  = ~full_sum[DATA_W];
    end

endmodule

// File: rtl/approx_sub_pipe.sv
// Two-stage valid/ready approximate subtractor with per-transaction exact override
// and a saturating counter of results that differ from the exact difference.
module approx_sub_pipe
    import approx_sub_pipe_pkg::*;
#(
    parameter int unsigned ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              borrow_in,
    input  logic              exact_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow_out,
    output logic [ERR_W-1:0]  err_count,
    input  logic              err_clr
);

    logic              s1_valid;
    stage_t            s1_q;
    logic              s2_valid;
    logic              s2_mis;
    logic              s2_move;
    logic              out_fire;

    logic [DATA_W-1:0] approx_diff;
    logic              approx_borrow;
    logic [DATA_W-1:0] exact_diff;
    logic              exact_borrow;

    // Handshake: a stalled output freezes stage 2, which in turn freezes a full stage 1
    always_comb begin
        s2_move  = ~s2_valid | out_ready;
        in_ready = ~s1_valid | s2_move;
        out_fire = s2_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{a: a, b: b, borrow_in: borrow_in, exact_mode: exact_mode};
            end
        end
    end

    approx_sub_core u_core (
        .a             (s1_q.a),
        .b             (s1_q.b),
        .borrow_in     (s1_q.borrow_in),
        .approx_diff   (approx_diff),
        .approx_borrow (approx_borrow),
        .exact_diff    (exact_diff),
        .exact_borrow  (exact_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_mis     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (s2_move) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff       <= s1_q.exact_mode ? exact_diff : approx_diff;
                borrow_out <= s1_q.exact_mode ? exact_borrow : approx_borrow;
                s2_mis     <= ~s1_q.exact_mode
                            & ({approx_borrow, approx_diff} != {exact_borrow, exact_diff});
            end
        end
    end

    assign out_valid = s2_valid;

    // Clear has priority; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= '0;
        end else if (out_fire && s2_mis && !(&err_count)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: doc/approx_sub_pipe.md
Name: approx_sub_pipe

Overview:
- Pipelined 24-bit approximate subtractor; the inverse-direction companion to the team's 24-bit precise/approximate adder, used on the DCT butterfly difference paths.
- Upper 8 bits are subtracted exactly with borrow. Lower 16 bits use the OR-based approximation applied to A + ~B.
- Two-stage valid/ready pipeline with a per-transaction exact-mode override.
- Saturating counter of delivered results that differ from the exact difference, for on-chip error profiling.

Parameters:
- ERR_W, 16, width of the mismatch counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand transaction valid
- in_ready  output  1  block can accept an operand transaction
- a  input  24  minuend
- b  input  24  subtrahend
- borrow_in  input  1  active-high borrow into the upper 8 bits
- exact_mode  input  1  1 = full exact 24-bit subtract for this transaction
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  24  difference
- borrow_out  output  1  active-high borrow out
- err_count  output  ERR_W  saturating mismatch count
- err_clr  input  1  synchronous clear of err_count

Behaviour:
- Arithmetic, with bi = ~b:
  - Approximate mode: diff[15:0] = a[15:0] | bi[15:0]. c_lo = a[15] & bi[15]. {c_hi, diff[23:16]} = a[23:16] + bi[23:16] + ~borrow_in. borrow_out = ~(c_hi | c_lo).
  - Exact mode: {c, diff} = a + bi + ~borrow_in, 25-bit add; borrow_out = ~c.
  - Both results are computed every transaction. The exact result is always kept for error comparison.
- Stage 1 registers the operands, borrow_in and exact_mode on an in_valid & in_ready handshake.
- Stage 2 registers diff, borrow_out and a mismatch flag. The mismatch flag is set when the approximate {borrow_out, diff} differs from the exact one and exact_mode = 0.
- Latency: the result is presented 2 cycles after the accepting edge. Throughput is 1 per cycle when out_ready = 1.
- Flow control:
  - s2 moves when ~s2_valid | out_ready.
  - s1 moves when s2 moves.
  - in_ready = ~s1_valid | s2 moves; this is combinational from out_ready.
  - No bubbles under continuous flow. Maximum 2 transactions in flight.
- Output stability: while out_valid = 1 and out_ready = 0, diff and borrow_out are held stable. In that state a stage does not load new data.
- err_count:
  - Increments by 1 on an out_valid & out_ready handshake whose mismatch flag is 1.
  - Saturates at all-ones.
  - err_clr forces 0 and wins over a simultaneous increment.
- Reset:
  - Resets s1_valid, s2_valid and err_count to 0, so out_valid = 0 and in_ready = 1 after reset.
  - diff and borrow_out reset to 0.
  - In-flight transactions are discarded, including when reset is asserted mid-stream or during a stall.
- exact_mode is sampled per transaction. Mixed-mode streams are legal and keep their order.

Decomposition:
- Shared package holds:
  - DATA_W = 24, PREC_W = 8, APPROX_W = 16.
  - A struct for the stage payload {a, b, borrow_in, exact_mode}.
- One combinational sub-module, approx_sub_core. Inputs: a, b, borrow_in. Outputs: approx diff/borrow and exact diff/borrow. It is instantiated between stage 1 and stage 2.
- The pipeline, handshake logic and counter stay in approx_sub_pipe.

Test Plan:
1. a=0x123456, b=0x010203, borrow_in=0, exact_mode=0, out_ready=1 -> 2 cycles later diff=0x11FDFE, borrow_out=0, err_count goes 0->1.
2. Same operands with exact_mode=1 -> diff=0x113253, borrow_out=0, err_count unchanged.
3. a=0, b=0 in approximate mode -> diff=0x00FFFF, borrow_out=0, mismatch counted. a=0, b=1 in exact mode -> diff=0xFFFFFF, borrow_out=1.
4. Stream 4 transactions with out_ready=0 for 5 cycles:
   - in_ready drops after 2 accepts.
   - Output is held at the first result.
   - After releasing out_ready, all 4 results emerge in order with no loss or duplication.
5. Preload err_count to all-ones by forcing or long run, then send a mismatching transaction -> count stays 0xFFFF. Assert err_clr on the same cycle as a mismatch handshake -> count = 0.
6. Assert rst with 2 transactions in flight and out_ready=0 -> next cycle out_valid=0, in_ready=1, err_count=0, and no stale result ever appears.
